cl_decode_pipe: RTL and testbench

CL_DECODE_PIPE -- requirements
Module: cl_decode_pipe

---
 rtl/cl_decode_pipe.sv | 177 +++++++++++++++++
 tb/tb_cl_decode_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_decode_pipe.sv
// cl_decode_pipe: instruction decode stage with one output register and one
// skid entry. Optional load-use hazard scoreboard and stall counter are built
// only when CL_DECODE_HAZARD_EN is defined; otherwise hazard and the stall
// count are tied to zero.
// Instruction layout: {opcode[5:0], rd[RF_ADDR_W-1:0], rs[RF_ADDR_W-1:0]} in
// the low 6+2*RF_ADDR_W bits of the instruction word.
module cl_decode_pipe #(
  parameter int          INSTR_W   = 16,
  parameter int          RF_ADDR_W = 5,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic               flush_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [INSTR_W-1:0] dec_instr_o,
  output logic               is_load_op_o,
  output logic               op_writes_rf_o,
  output logic               is_store_op_o,
  output logic               is_mem_op_o,
  output logic               is_byte_op_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int OPC_LSB = 2 * RF_ADDR_W;

  typedef enum logic [5:0] {
    kADDU = 6'd0,  kSUBU = 6'd1,  kSLLV = 6'd2,  kSRAV = 6'd3,
    kSRLV = 6'd4,  kAND  = 6'd5,  kOR   = 6'd6,  kNOR  = 6'd7,
    kSLT  = 6'd8,  kSLTU = 6'd9,  kMOV  = 6'd10, kJALR = 6'd11,
    kLW   = 6'd12, kLBU  = 6'd13, kSW   = 6'd14, kSB   = 6'd15,
    kBRLU = 6'd16, kXOR  = 6'd17, kROR  = 6'd18, kBEQZ = 6'd19,
    kBNEZ = 6'd20, kLI   = 6'd21, kJ    = 6'd22
  } opcode_e;

  typedef struct packed {
    logic load;
    logic writes;
    logic store;
    logic mem;
    logic byte_op;
  } flags_t;

  function automatic flags_t f_decode(input logic [5:0] opc);
    flags_t f;
    f = '0;
    case (opcode_e'(opc))
      kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR,
      kSLT, kSLTU, kMOV, kJALR, kBRLU, kXOR, kROR: f.writes = 1'b1;
      kLW:  begin f.load = 1'b1; f.writes = 1'b1; f.mem = 1'b1; end
      kLBU: begin f.load = 1'b1; f.writes = 1'b1; f.mem = 1'b1; f.byte_op = 1'b1; end
      kSW:  begin f.store = 1'b1; f.mem = 1'b1; end
      kSB:  begin f.store = 1'b1; f.mem = 1'b1; f.byte_op = 1'b1; end
      default: f = '0;
    endcase
    return f;
  endfunction

  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  flags_t             r_out_flags;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  flags_t             w_in_flags;
  flags_t             w_skid_flags;
  logic               w_hazard;
  logic               w_accept;
  logic               w_deq;

  assign w_in_flags    = f_decode(instr_i[OPC_LSB +: 6]);
  assign w_skid_flags  = f_decode(r_skid_instr[OPC_LSB +: 6]);
  assign instr_ready_o = reset_n & ~r_skid_valid & ~w_hazard & ~flush_i;
  assign w_accept      = instr_valid_i & instr_ready_o;
  assign w_deq         = r_out_valid & dec_ready_i;

  assign dec_valid_o    = r_out_valid;
  assign dec_instr_o    = r_out_instr;
  assign is_load_op_o   = r_out_flags.load;
  assign op_writes_rf_o = r_out_flags.writes;
  assign is_store_op_o  = r_out_flags.store;
  assign is_mem_op_o    = r_out_flags.mem;
  assign is_byte_op_o   = r_out_flags.byte_op;

  // Output register and skid entry: skid refills output first to keep order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_flags  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_deq) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= r_skid_instr;
        r_out_flags  <= w_skid_flags;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= instr_i;
        r_out_flags <= w_in_flags;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= instr_i;
    end
  end

`ifdef CL_DECODE_HAZARD_EN
  logic [RF_ADDR_W-1:0] w_in_rs;
  logic [RF_ADDR_W-1:0] w_in_rd;
  logic [RF_ADDR_W-1:0] w_out_rd;
  logic [RF_ADDR_W-1:0] w_skid_rd;
  logic [LOAD_LAT-1:0]  r_sb_valid;
  logic [RF_ADDR_W-1:0] r_sb_rd [LOAD_LAT];
  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_in_rs     = instr_i[0 +: RF_ADDR_W];
  assign w_in_rd     = instr_i[RF_ADDR_W +: RF_ADDR_W];
  assign w_out_rd    = r_out_instr[RF_ADDR_W +: RF_ADDR_W];
  assign w_skid_rd   = r_skid_instr[RF_ADDR_W +: RF_ADDR_W];
  assign stall_cnt_o = r_stall_cnt;

  // Hazard: incoming rs/rd matches a pending load destination
  always_comb begin
    w_hazard = 1'b0;
    if (r_out_valid && r_out_flags.load &&
        (w_in_rs == w_out_rd || w_in_rd == w_out_rd))
      w_hazard = 1'b1;
    if (r_skid_valid && w_skid_flags.load &&
        (w_in_rs == w_skid_rd || w_in_rd == w_skid_rd))
      w_hazard = 1'b1;
    for (int unsigned i = 0; i < LOAD_LAT; i++) begin
      if (r_sb_valid[i] && (w_in_rs == r_sb_rd[i] || w_in_rd == r_sb_rd[i]))
        w_hazard = 1'b1;
    end
  end

  // Scoreboard shift register; a dequeue during flush still inserts its load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sb_valid <= '0;
      for (int unsigned i = 0; i < LOAD_LAT; i++) r_sb_rd[i] <= '0;
    end else begin
      r_sb_valid[0] <= w_deq & r_out_flags.load;
      r_sb_rd[0]    <= w_out_rd;
      for (int unsigned i = 1; i < LOAD_LAT; i++) begin
        r_sb_valid[i] <= r_sb_valid[i-1];
        r_sb_rd[i]    <= r_sb_rd[i-1];
      end
    end
  end

  // Saturating count of cycles spent stalled on a hazard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (instr_valid_i && w_hazard && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  assign w_hazard    = 1'b0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cl_decode_pipe.sv
// Testbench for cl_decode_pipe: decode table, skid ordering, flush, and
// (with CL_DECODE_HAZARD_EN) load-use stalls and stall-counter saturation.
module tb_cl_decode_pipe;
  localparam int          INSTR_W   = 16;
  localparam int          RF_ADDR_W = 5;
  localparam int unsigned LOAD_LAT  = 2;
  localparam int          CNT_W     = 16;

  localparam logic [5:0] OP_ADDU = 6'd0,  OP_SUBU = 6'd1,  OP_SLLV = 6'd2;
  localparam logic [5:0] OP_NOR  = 6'd7,  OP_SLTU = 6'd9,  OP_MOV  = 6'd10;
  localparam logic [5:0] OP_JALR = 6'd11, OP_LW   = 6'd12, OP_LBU  = 6'd13;
  localparam logic [5:0] OP_SW   = 6'd14, OP_SB   = 6'd15, OP_BRLU = 6'd16;
  localparam logic [5:0] OP_XOR  = 6'd17, OP_ROR  = 6'd18, OP_BEQZ = 6'd19;
  localparam logic [5:0] OP_J    = 6'd22, OP_MAX  = 6'd63;

  logic               clk;
  logic               reset_n;
  logic [INSTR_W-1:0] instr_i;
  logic               instr_valid_i;
  logic               instr_ready_o;
  logic               flush_i;
  logic               dec_valid_o;
  logic               dec_ready_i;
  logic [INSTR_W-1:0] dec_instr_o;
  logic               is_load_op_o, op_writes_rf_o, is_store_op_o, is_mem_op_o, is_byte_op_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [4:0]         dut_flags;

  cl_decode_pipe #(
    .INSTR_W  (INSTR_W),
    .RF_ADDR_W(RF_ADDR_W),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .flush_i       (flush_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .is_load_op_o  (is_load_op_o),
    .op_writes_rf_o(op_writes_rf_o),
    .is_store_op_o (is_store_op_o),
    .is_mem_op_o   (is_mem_op_o),
    .is_byte_op_o  (is_byte_op_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  assign dut_flags = {is_load_op_o, op_writes_rf_o, is_store_op_o, is_mem_op_o, is_byte_op_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags order: {load, writes_rf, store, mem, byte}
  typedef struct packed {
    logic [15:0] instr;
    logic [4:0]  flags;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs);
    return {op, rd, rs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one instruction until accepted (bounded); expected result queued on acceptance
  task automatic send(input logic [15:0] ins, input logic [4:0] flags, output int waits);
    bit acc;
    acc   = 0;
    waits = 0;
    instr_i       = ins;
    instr_valid_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (instr_ready_o) begin
        q.push_back('{instr: ins, flags: flags});
        acc = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    instr_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got not-accepted expected accepted for %0h", ins);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n       = 1'b0;
    instr_valid_i = 1'b0;
    flush_i       = 1'b0;
    q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Output monitor: scoreboard pop on dequeue, and stability while held
  logic        prev_hold;
  logic [15:0] prev_instr;
  initial prev_hold = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, dec_valid_o}, 32'd1);
        check("hold_instr", {16'd0, dec_instr_o}, {16'd0, prev_instr});
      end
      if (dec_valid_o && dec_ready_i) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL deq_unexpected: got instr %0h expected no output", dec_instr_o);
        end else begin
          mon_e = q.pop_front();
          check("deq_instr", {16'd0, dec_instr_o}, {16'd0, mon_e.instr});
          check("deq_flags", {27'd0, dut_flags}, {27'd0, mon_e.flags});
        end
      end
      if (flush_i) q.delete();
      prev_hold  = dec_valid_o && !dec_ready_i && !flush_i;
      prev_instr = dec_instr_o;
    end else begin
      prev_hold = 1'b0;
    end
  end

  typedef struct {
    logic [5:0] op;
    logic [4:0] flags;
  } vec_t;

  vec_t vecs [14];
  int   w;
  int   stalls;
  bit   acc2;

  initial begin
    vecs[0]  = '{OP_ADDU, 5'b01000};
    vecs[1]  = '{OP_SUBU, 5'b01000};
    vecs[2]  = '{OP_SLLV, 5'b01000};
    vecs[3]  = '{OP_NOR,  5'b01000};
    vecs[4]  = '{OP_SLTU, 5'b01000};
    vecs[5]  = '{OP_MOV,  5'b01000};
    vecs[6]  = '{OP_JALR, 5'b01000};
    vecs[7]  = '{OP_LW,   5'b11010};
    vecs[8]  = '{OP_LBU,  5'b11011};
    vecs[9]  = '{OP_SW,   5'b00110};
    vecs[10] = '{OP_SB,   5'b00111};
    vecs[11] = '{OP_BRLU, 5'b01000};
    vecs[12] = '{OP_BEQZ, 5'b00000};
    vecs[13] = '{OP_MAX,  5'b00000};

    reset_n       = 1'b0;
    flush_i       = 1'b0;
    dec_ready_i   = 1'b0;
    instr_valid_i = 1'b1;
    instr_i       = mk(OP_LW, 5'd1, 5'd2);
    repeat (2) @(negedge clk);
    check("rst_dec_valid", {31'd0, dec_valid_o}, 32'd0);
    check("rst_ready",     {31'd0, instr_ready_o}, 32'd0);
    check("rst_instr",     {16'd0, dec_instr_o}, 32'd0);
    check("rst_flags",     {27'd0, dut_flags}, 32'd0);
    check("rst_stall",     {16'd0, stall_cnt_o}, 32'd0);
    instr_valid_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, instr_ready_o}, 32'd1);
    @(posedge clk); #1;

    // kADDU r1 appears next cycle with only writes_rf set
    dec_ready_i = 1'b1;
    send(mk(OP_ADDU, 5'd1, 5'd2), 5'b01000, w);
    @(negedge clk);
    check("addu_valid", {31'd0, dec_valid_o}, 32'd1);
    check("addu_flags", {27'd0, dut_flags}, 32'b01000);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      send(mk(vecs[i].op, 5'd1, 5'd2), vecs[i].flags, w);
      repeat (4) @(posedge clk);
      #1;
    end

    // Two held behind a stalled output, third refused, then ordered drain
    dec_ready_i = 1'b0;
    send(mk(OP_ADDU, 5'd4, 5'd5), 5'b01000, w);
    send(mk(OP_XOR,  5'd6, 5'd7), 5'b01000, w);
    instr_i       = mk(OP_ROR, 5'd8, 5'd9);
    instr_valid_i = 1'b1;
    @(negedge clk);
    check("full_ready0_a", {31'd0, instr_ready_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_ready0_b", {31'd0, instr_ready_o}, 32'd0);
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    dec_ready_i   = 1'b1;
    @(negedge clk);
    check("drain_first",  {16'd0, dec_instr_o}, {16'd0, mk(OP_ADDU, 5'd4, 5'd5)});
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_second_valid", {31'd0, dec_valid_o}, 32'd1);
    check("drain_second", {16'd0, dec_instr_o}, {16'd0, mk(OP_XOR, 5'd6, 5'd7)});
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_empty", {31'd0, dec_valid_o}, 32'd0);
    @(posedge clk); #1;
    send(mk(OP_ROR, 5'd8, 5'd9), 5'b01000, w);
    repeat (4) @(posedge clk);
    #1;

    // Flush with output and skid full, no dequeue
    dec_ready_i = 1'b0;
    send(mk(OP_SB, 5'd8, 5'd9), 5'b00111, w);
    send(mk(OP_SW, 5'd10, 5'd11), 5'b00110, w);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_ready0", {31'd0, instr_ready_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_valid0", {31'd0, dec_valid_o}, 32'd0);
    check("flush_skid_empty", {31'd0, instr_ready_o}, 32'd1);
    @(posedge clk); #1;

    // Flush coinciding with a load dequeue: the load still blocks its reader
    send(mk(OP_LW, 5'd3, 5'd12), 5'b11010, w);
    flush_i     = 1'b1;
    dec_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    instr_i = mk(OP_ADDU, 5'd13, 5'd3);
    @(negedge clk);
    check("flushdeq_valid0", {31'd0, dec_valid_o}, 32'd0);
`ifdef CL_DECODE_HAZARD_EN
    check("flushdeq_blocks", {31'd0, instr_ready_o}, 32'd0);
`else
    check("flushdeq_noblock", {31'd0, instr_ready_o}, 32'd1);
`endif
    repeat (4) @(posedge clk);
    #1;

`ifdef CL_DECODE_HAZARD_EN
    // Load-use stall: one cycle in output register plus LOAD_LAT scoreboard cycles
    do_reset();
    dec_ready_i = 1'b1;
    send(mk(OP_LW, 5'd3, 5'd14), 5'b11010, w);
    instr_i       = mk(OP_ADDU, 5'd15, 5'd3);
    instr_valid_i = 1'b1;
    stalls = 0;
    acc2   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_ready_o) begin
        q.push_back('{instr: mk(OP_ADDU, 5'd15, 5'd3), flags: 5'b01000});
        acc2 = 1;
      end else begin
        check("stall_cnt_step", {16'd0, stall_cnt_o}, stalls);
        stalls++;
      end
      @(posedge clk); #1;
      if (acc2) break;
    end
    instr_valid_i = 1'b0;
    check("stall_cycles", stalls, 32'd3);
    @(negedge clk);
    check("stall_cnt_total", {16'd0, stall_cnt_o}, 32'd3);
    @(posedge clk); #1;

    // Sustained hazard saturates the counter; async reset clears it at once
    do_reset();
    dec_ready_i = 1'b0;
    send(mk(OP_LW, 5'd3, 5'd14), 5'b11010, w);
    instr_i       = mk(OP_ADDU, 5'd15, 5'd3);
    instr_valid_i = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    check("stall_sat", {16'd0, stall_cnt_o}, 32'hFFFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_sat_hold", {16'd0, stall_cnt_o}, 32'hFFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_stall", {16'd0, stall_cnt_o}, 32'd0);
    check("midrst_valid", {31'd0, dec_valid_o}, 32'd0);
    check("midrst_ready", {31'd0, instr_ready_o}, 32'd0);
    instr_valid_i = 1'b0;
    q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", {31'd0, instr_ready_o}, 32'd1);
    @(posedge clk); #1;
`else
    // No hazard logic: a load and its reader go back-to-back
    dec_ready_i = 1'b1;
    send(mk(OP_LW, 5'd3, 5'd16), 5'b11010, w);
    send(mk(OP_ADDU, 5'd17, 5'd3), 5'b01000, w);
    check("b2b_waits", w, 32'd0);
    @(negedge clk);
    check("b2b_stall0", {16'd0, stall_cnt_o}, 32'd0);
    @(posedge clk); #1;
    send(mk(OP_J, 5'd3, 5'd3), 5'b00000, w);
`endif

    dec_ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
